// File: rtl/mp64_extmem_arb.sv
// Round-robin arbiter sharing the single external-memory PHY port among NREQ masters.
// One transaction in flight at a time; read beats steer to the owner, completion/error pulse back.
module mp64_extmem_arb #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NREQ-1:0]    m_req,
  input  logic [NREQ-1:0]    m_wen,
  input  logic [NREQ*32-1:0] m_addr,
  input  logic [NREQ*64-1:0] m_wdata,
  input  logic [NREQ*4-1:0]  m_blen,
  output logic [NREQ-1:0]    m_gnt,
  output logic [NREQ-1:0]    m_rvalid,
  output logic [63:0]        m_rdata,
  output logic [NREQ-1:0]    m_done,
  output logic [NREQ-1:0]    m_err,
  output logic               phy_req,
  output logic [31:0]        phy_addr,
  output logic               phy_wen,
  output logic [63:0]        phy_wdata,
  output logic [3:0]         phy_burst_len,
  input  logic [63:0]        phy_rdata,
  input  logic               phy_rvalid,
  input  logic               phy_ready,
  output logic               busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [31:0]     addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [3:0]      blen_q, blen_d;
  logic [4:0]      beat_q, beat_d;
  logic            seen_busy_q, seen_busy_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            phy_req_q, phy_req_d;
  logic            busy_q, busy_d;

  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] cand;
  logic [NREQ-1:0] winner_oh, owner_oh;
  logic [31:0]     sel_addr;
  logic [63:0]     sel_wdata;
  logic [3:0]      sel_blen;
  logic            sel_wen;
  logic [4:0]      beat_inc;
  logic            beat_bad;

  // Scan last+NREQ down to last+1 so the nearest requester after last is the final assignment.
  always_comb begin
    winner = last_q;
    cand   = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      cand = IdxW'((int'(last_q) + k) % int'(NREQ));
      if (m_req[cand]) winner = cand;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_blen  = '0;
    sel_wen   = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (winner == IdxW'(i)) begin
        sel_addr  = m_addr[32*i +: 32];
        sel_wdata = m_wdata[64*i +: 64];
        sel_blen  = m_blen[4*i +: 4];
        sel_wen   = m_wen[i];
      end
    end
  end

  assign winner_oh = NREQ'(1) << winner;
  assign owner_oh  = NREQ'(1) << owner_q;

  // Saturate so a runaway PHY cannot wrap the count back onto the expected value.
  assign beat_inc = (phy_rvalid && (beat_q != 5'd31)) ? beat_q + 5'd1 : beat_q;
  assign beat_bad = wen_q ? (beat_inc != 5'd0) : (beat_inc != ({1'b0, blen_q} + 5'd1));

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    blen_d      = blen_q;
    beat_d      = beat_q;
    seen_busy_d = seen_busy_q;
    timer_d     = timer_q;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = '0;
    phy_req_d   = 1'b0;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if ((|m_req) && phy_ready) begin
          owner_d   = winner;
          addr_d    = sel_addr;
          wen_d     = sel_wen;
          wdata_d   = sel_wdata;
          blen_d    = sel_wen ? 4'd0 : sel_blen;
          gnt_d     = winner_oh;
          phy_req_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        beat_d      = '0;
        seen_busy_d = 1'b0;
        timer_d     = '0;
        state_d     = StWait;
      end
      StWait: begin
        beat_d  = beat_inc;
        timer_d = timer_q + TmrW'(1);
        if (!phy_ready) seen_busy_d = 1'b1;
        if (phy_ready && seen_busy_q) begin
          done_d  = owner_oh;
          err_d   = beat_bad ? owner_oh : '0;
          state_d = StDone;
        end else if (timer_q == TmrW'(TIMEOUT_CYC - 1)) begin
          done_d  = owner_oh;
          err_d   = owner_oh;
          state_d = StDone;
        end
      end
      StDone: begin
        last_d  = owner_q;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      last_q      <= IdxW'(NREQ - 1);
      owner_q     <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      blen_q      <= '0;
      beat_q      <= '0;
      seen_busy_q <= 1'b0;
      timer_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      phy_req_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      blen_q      <= blen_d;
      beat_q      <= beat_d;
      seen_busy_q <= seen_busy_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      phy_req_q   <= phy_req_d;
      busy_q      <= busy_d;
    end
  end

  assign m_gnt         = gnt_q;
  assign m_done        = done_q;
  assign m_err         = err_q;
  assign phy_req       = phy_req_q;
  assign phy_addr      = addr_q;
  assign phy_wen       = wen_q;
  assign phy_wdata     = wdata_q;
  assign phy_burst_len = blen_q;
  assign busy          = busy_q;
  // Beats only reach a master while a transaction is waiting; stray PHY beats are dropped.
  assign m_rvalid      = ((state_q == StWait) && phy_rvalid) ? owner_oh : '0;
  assign m_rdata       = (state_q == StWait) ? phy_rdata : '0;

endmodule

// File: tb/tb_mp64_extmem_arb.sv
// Bench for mp64_extmem_arb: behavioural PHY with memory, vector table, corner sequences and
// randomized transactions checked against a round-robin reference model.
module tb_mp64_extmem_arb;
  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [NREQ-1:0]    m_req, m_wen, m_gnt, m_rvalid, m_done, m_err;
  logic [NREQ*32-1:0] m_addr;
  logic [NREQ*64-1:0] m_wdata;
  logic [NREQ*4-1:0]  m_blen;
  logic [63:0]        m_rdata, phy_wdata, phy_rdata;
  logic               phy_req, phy_wen, phy_rvalid, phy_ready, busy;
  logic [31:0]        phy_addr;
  logic [3:0]         phy_burst_len;

  mp64_extmem_arb #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_blen(m_blen), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_done(m_done), .m_err(m_err), .phy_req(phy_req), .phy_addr(phy_addr), .phy_wen(phy_wen),
    .phy_wdata(phy_wdata), .phy_burst_len(phy_burst_len), .phy_rdata(phy_rdata),
    .phy_rvalid(phy_rvalid), .phy_ready(phy_ready), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  logic [NREQ-1:0] req_v, wen_v;
  logic [31:0]     cfg_addr  [NREQ];
  logic [63:0]     cfg_wdata [NREQ];
  logic [3:0]      cfg_blen  [NREQ];

  logic [63:0] mem [2048];
  bit          phy_busy, phy_hold, phy_stuck;
  int          phy_lat, phy_left, phy_idx, phy_adj, phy_lat_set;
  logic [31:0] cap_addr;
  logic [3:0]  cap_blen;

  int          cyc, gnt_cnt, done_cnt, req_cycles, gnt_cyc, done_cyc;
  logic [3:0]  gnt_vec, done_vec, err_vec, rv_or;
  logic        busy_gnt, busy_done;
  logic [31:0] done_addr;
  logic [63:0] beats [$];
  int          model_last;

  typedef struct {
    logic [3:0] req;
    logic [3:0] wen;
    logic [3:0] blen;
    int         lat;
    int         adj;
    int         exp_owner;
    bit         exp_err;
    int         exp_cnt;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event within bound, required one", name);
  endtask

  task automatic apply();
    m_req = req_v;
    m_wen = wen_v;
    for (int i = 0; i < NREQ; i++) begin
      m_addr[32*i +: 32]  = cfg_addr[i];
      m_wdata[64*i +: 64] = cfg_wdata[i];
      m_blen[4*i +: 4]    = cfg_blen[i];
    end
  endtask

  // PHY: drops ready after accepting, waits lat_set+1 ticks, streams burst_len+1+adj beats, ready.
  task automatic phy_tick();
    phy_rvalid = 1'b0;
    phy_rdata  = '0;
    if (phy_hold) begin
      phy_ready = 1'b0;
      return;
    end
    if (!phy_busy && phy_req) begin
      cap_addr  = phy_addr;
      cap_blen  = phy_burst_len;
      phy_idx   = int'(phy_addr[13:3]);
      if (phy_wen) mem[phy_idx] = phy_wdata;
      phy_left  = (phy_wen ? 0 : int'(phy_burst_len) + 1) + phy_adj;
      phy_lat   = phy_lat_set + 1;
      phy_ready = 1'b0;
      if (phy_stuck) phy_hold = 1'b1;
      else phy_busy = 1'b1;
    end else if (phy_busy) begin
      if (phy_lat > 0) begin
        phy_lat--;
      end else if (phy_left > 0) begin
        phy_rvalid = 1'b1;
        phy_rdata  = mem[phy_idx % 2048];
        phy_idx++;
        phy_left--;
      end else begin
        phy_ready = 1'b1;
        phy_busy  = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    phy_tick();
    #1;
    cyc++;
    if (phy_req) req_cycles++;
    if (|m_gnt) begin
      gnt_cnt++;
      gnt_vec  = m_gnt;
      gnt_cyc  = cyc;
      busy_gnt = busy;
    end
    if (|m_rvalid) begin
      rv_or |= m_rvalid;
      beats.push_back(m_rdata);
    end
    if (|m_done) begin
      done_cnt++;
      done_vec  = m_done;
      err_vec   = m_err;
      done_cyc  = cyc;
      busy_done = busy;
      done_addr = phy_addr;
    end
  endtask

  task automatic clear_mon();
    gnt_cnt = 0; done_cnt = 0; req_cycles = 0;
    gnt_vec = '0; done_vec = '0; err_vec = '0; rv_or = '0;
    beats.delete();
  endtask

  function automatic int model_winner(input logic [3:0] req);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (model_last + k) % NREQ;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " m_gnt"}, 64'(m_gnt), 0);
    chk({tag, " m_rvalid"}, 64'(m_rvalid), 0);
    chk({tag, " m_rdata"}, m_rdata, 0);
    chk({tag, " m_done"}, 64'(m_done), 0);
    chk({tag, " m_err"}, 64'(m_err), 0);
    chk({tag, " phy_req"}, 64'(phy_req), 0);
    chk({tag, " phy_addr"}, 64'(phy_addr), 0);
    chk({tag, " phy_wen"}, 64'(phy_wen), 0);
    chk({tag, " phy_wdata"}, phy_wdata, 0);
    chk({tag, " phy_burst_len"}, 64'(phy_burst_len), 0);
    chk({tag, " busy"}, 64'(busy), 0);
  endtask

  task automatic wait_gnt(input string tag, input int exp_owner, output bit ok);
    int n;
    n = 0;
    while (gnt_cnt == 0 && n < 60) begin step(); n++; end
    ok = (gnt_cnt != 0);
    if (!ok) begin note_miss({tag, " grant"}); return; end
    chk({tag, " gnt owner"}, 64'(gnt_vec), 64'(4'b1 << exp_owner));
    chk({tag, " busy at gnt"}, 64'(busy_gnt), 1);
  endtask

  task automatic finish_txn(input string tag, input int owner, input bit exp_err,
                            input int exp_cnt);
    int n, base;
    n = 0;
    while (done_cnt == 0 && n < TMO + 60) begin step(); n++; end
    if (done_cnt == 0) begin note_miss({tag, " done"}); return; end
    base = int'(cfg_addr[owner][13:3]);
    chk({tag, " done"}, 64'(done_vec), 64'(4'b1 << owner));
    chk({tag, " err"}, 64'(err_vec), exp_err ? 64'(4'b1 << owner) : 64'd0);
    chk({tag, " gnt count"}, 64'(gnt_cnt), 1);
    chk({tag, " phy_req cycles"}, 64'(req_cycles), 1);
    chk({tag, " busy at done"}, 64'(busy_done), 1);
    chk({tag, " phy_addr"}, 64'(cap_addr), 64'(cfg_addr[owner]));
    chk({tag, " phy_addr at done"}, 64'(done_addr), 64'(cfg_addr[owner]));
    chk({tag, " burst_len"}, 64'(cap_blen), wen_v[owner] ? 64'd0 : 64'(cfg_blen[owner]));
    chk({tag, " beat count"}, 64'(beats.size()), 64'(exp_cnt));
    chk({tag, " rvalid target"}, 64'(rv_or), exp_cnt > 0 ? 64'(4'b1 << owner) : 64'd0);
    for (int k = 0; k < beats.size(); k++)
      chk($sformatf("%s beat%0d", tag, k), beats[k], mem[(base + k) % 2048]);
    if (wen_v[owner]) chk({tag, " mem write"}, mem[base], cfg_wdata[owner]);
    model_last = owner;
  endtask

  task automatic run_txn(input string tag, input int exp_owner, input bit exp_err,
                         input int exp_cnt, input bit drop);
    bit ok;
    clear_mon();
    wait_gnt(tag, exp_owner, ok);
    if (!ok) return;
    if (drop) begin req_v[exp_owner] = 1'b0; apply(); end
    finish_txn(tag, exp_owner, exp_err, exp_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int r_cyc;
    phy_ready = 1'b1; phy_rvalid = 1'b0; phy_rdata = '0;
    phy_busy = 0; phy_hold = 0; phy_stuck = 0; phy_adj = 0; phy_lat_set = 0;
    cyc = 0; model_last = NREQ - 1;
    for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};
    cfg_addr[0] = 32'h0000_0100; cfg_addr[1] = 32'h0000_0208;
    cfg_addr[2] = 32'h0000_2000; cfg_addr[3] = 32'h0000_03F8;
    cfg_wdata[0] = 64'h0123_4567_89AB_CDEF; cfg_wdata[1] = 64'h1111_2222_3333_4444;
    cfg_wdata[2] = 64'hDEAD_BEEF_CAFE_F00D; cfg_wdata[3] = 64'h5A5A_A5A5_0F0F_F0F0;
    for (int i = 0; i < NREQ; i++) cfg_blen[i] = '0;
    req_v = '0; wen_v = '0;
    apply();
    clear_mon();

    repeat (3) step();
    check_zero("reset");
    sys_rst_n = 1'b1;

    //           req      wen      blen lat adj own err cnt
    tbl[0]  = '{4'b0001, 4'b0000, 4'd3,  0,  0, 0, 0, 4};
    tbl[1]  = '{4'b0011, 4'b0000, 4'd1,  1,  0, 1, 0, 2};
    tbl[2]  = '{4'b0011, 4'b0000, 4'd0,  2,  0, 0, 0, 1};
    tbl[3]  = '{4'b0011, 4'b0000, 4'd2,  0,  0, 1, 0, 3};
    tbl[4]  = '{4'b1011, 4'b0000, 4'd0,  0,  0, 3, 0, 1};
    tbl[5]  = '{4'b1011, 4'b0000, 4'd15, 0,  0, 0, 0, 16};
    tbl[6]  = '{4'b0100, 4'b0100, 4'd5,  0,  0, 2, 0, 0};
    tbl[7]  = '{4'b0100, 4'b0000, 4'd2,  0,  1, 2, 1, 4};
    tbl[8]  = '{4'b0010, 4'b0000, 4'd3,  1, -1, 1, 1, 3};
    tbl[9]  = '{4'b1000, 4'b1000, 4'd7,  0,  1, 3, 1, 1};
    tbl[10] = '{4'b1111, 4'b0000, 4'd0,  0,  0, 0, 0, 1};
    tbl[11] = '{4'b1111, 4'b1111, 4'd9,  0,  0, 1, 0, 0};
    tbl[12] = '{4'b0101, 4'b0000, 4'd1,  0,  0, 2, 0, 2};
    for (int r = 0; r < 13; r++) begin
      req_v = tbl[r].req;
      wen_v = tbl[r].wen;
      for (int i = 0; i < NREQ; i++) cfg_blen[i] = tbl[r].blen;
      phy_lat_set = tbl[r].lat;
      phy_adj     = tbl[r].adj;
      apply();
      run_txn($sformatf("vec%0d", r), tbl[r].exp_owner, tbl[r].exp_err, tbl[r].exp_cnt, 1'b0);
    end

    // PHY stuck busy: timeout, then no grant while ready is low, grant right after it rises.
    req_v = 4'b0010; wen_v = '0; phy_adj = 0; phy_lat_set = 0; phy_stuck = 1;
    for (int i = 0; i < NREQ; i++) cfg_blen[i] = 4'd3;
    apply();
    clear_mon();
    wait_gnt("tmo", 1, ok);
    if (ok) begin
      finish_txn("tmo", 1, 1'b1, 0);
      chk("tmo latency", 64'(done_cyc - gnt_cyc), 64'(TMO + 1));
    end
    req_v = 4'b0001;
    apply();
    clear_mon();
    repeat (20) step();
    chk("no gnt while phy busy", 64'(gnt_cnt), 0);
    phy_stuck = 0; phy_hold = 0; phy_busy = 0; phy_ready = 1'b1;
    r_cyc = cyc;
    wait_gnt("ready gnt", 0, ok);
    if (ok) begin
      chk("ready gnt timing", 64'(gnt_cyc), 64'(r_cyc + 1));
      finish_txn("ready gnt", 0, 1'b0, 4);
    end

    // Reset during beat 2 of an 8-beat read.
    req_v = 4'b0100; wen_v = '0;
    for (int i = 0; i < NREQ; i++) cfg_blen[i] = 4'd7;
    apply();
    clear_mon();
    for (int n = 0; n < 40 && beats.size() < 2; n++) step();
    chk("midreset reached beat2", 64'(beats.size()), 2);
    sys_rst_n = 1'b0;
    #1;
    check_zero("midreset");
    phy_busy = 0; phy_hold = 0; phy_ready = 1'b1; phy_rvalid = 1'b0;
    req_v = '0;
    apply();
    repeat (2) step();
    sys_rst_n = 1'b1;
    model_last = NREQ - 1;
    step();
    phy_rvalid = 1'b1;
    phy_rdata  = 64'hFFFF_0000_FFFF_0000;
    #1;
    chk("stray rvalid idle", 64'(m_rvalid), 0);
    phy_rvalid = 1'b0;
    req_v = 4'b0101;
    for (int i = 0; i < NREQ; i++) cfg_blen[i] = 4'd1;
    apply();
    run_txn("post reset", 0, 1'b0, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int own, cnt;
      bit drop;
      req_v = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        wen_v[i]     = ($urandom_range(0, 3) == 0);
        cfg_blen[i]  = 4'($urandom_range(0, 15));
        cfg_addr[i]  = {18'd0, 11'($urandom_range(0, 2000)), 3'd0};
        cfg_wdata[i] = {$urandom, $urandom};
      end
      phy_lat_set = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0:       phy_adj = 1;
        1:       phy_adj = -1;
        default: phy_adj = 0;
      endcase
      own = model_winner(req_v);
      if (wen_v[own] && phy_adj < 0) phy_adj = 0;
      cnt  = (wen_v[own] ? 0 : int'(cfg_blen[own]) + 1) + phy_adj;
      drop = ($urandom_range(0, 3) == 0);
      apply();
      run_txn($sformatf("rnd%0d", t), own, phy_adj != 0, cnt, drop);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
